// File: rtl/datapath_ctrl_pkg.sv
// Shared types and encodings for the datapath controller: states, opcodes,
// branch condition codes and datapath mux-select values.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_ADDI = 4'h4,
        OP_SUBI = 4'h5,
        OP_LDW  = 4'h8,
        OP_STW  = 4'h9,
        OP_BR   = 4'hC,
        OP_BL   = 4'hD,
        OP_RET  = 4'hE,
        OP_NOP  = 4'hF
    } opcode_t;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_Z  = 4'd1;
    localparam logic [3:0] COND_NZ = 4'd2;
    localparam logic [3:0] COND_C  = 4'd3;
    localparam logic [3:0] COND_NC = 4'd4;
    localparam logic [3:0] COND_N  = 4'd5;
    localparam logic [3:0] COND_NN = 4'd6;
    localparam logic [3:0] COND_V  = 4'd7;

    // Bit positions inside Flags = {N,Z,C,V}
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_REL  = 2'b01;
    localparam logic [1:0] PC_LR   = 2'b10;
    localparam logic [1:0] PC_VEC  = 2'b11;

    localparam logic [1:0] OP2_RD2 = 2'b00;
    localparam logic [1:0] OP2_IMM = 2'b01;
    localparam logic [1:0] OP2_ONE = 2'b10;

    // Register-file field selects: which Ir nibble addresses a port
    localparam logic [1:0] RSEL_NONE = 2'b00;
    localparam logic [1:0] RSEL_A    = 2'b01;
    localparam logic [1:0] RSEL_B    = 2'b10;
    localparam logic [1:0] RSEL_D    = 2'b11;

    function automatic logic is_alu(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

endpackage

// File: rtl/datapath_ctrl_cond_eval.sv
// Branch condition evaluator: condition field x {N,Z,C,V} -> taken.
// Purely combinational; codes above 7 never take.
module cond_eval
    import ctrl_pkg::*;
#(
    parameter int COND_W = 4
) (
    input  logic [COND_W-1:0] cond,
    input  logic [3:0]        flags,
    output logic              taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_Z:  taken = flags[FLAG_Z];
            COND_NZ: taken = !flags[FLAG_Z];
            COND_C:  taken = flags[FLAG_C];
            COND_NC: taken = !flags[FLAG_C];
            COND_N:  taken = flags[FLAG_N];
            COND_NN: taken = !flags[FLAG_N];
            COND_V:  taken = flags[FLAG_V];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer for the 16-bit datapath: fetch, decode, execute,
// memory and write-back, plus the memory request/ready handshake.
module datapath_ctrl
    import ctrl_pkg::*;
#(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter int          COND_W    = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Ir,
    input  logic [3:0]  Flags,
    input  logic        Test,
    input  logic        MemReady,
    output logic        MemReq,
    output logic        MemWrite,
    output logic        AluEn,
    output logic        AluWe,
    output logic        CFlag,
    output logic        ImmSel,
    output logic        IrWe,
    output logic        LrEn,
    output logic        LrSel,
    output logic        LrWe,
    output logic        MemEn,
    output logic        Op1Sel,
    output logic        PcEn,
    output logic        PcWe,
    output logic        RegWe,
    output logic        WdSel,
    output logic [1:0]  Op2Sel,
    output logic [1:0]  PcSel,
    output logic [1:0]  Rs1Sel,
    output logic [1:0]  RwSel,
    output logic        Halted
);

    state_t  state, next_state;
    opcode_t op;
    logic    taken;
    logic    mem_done;
    logic    unused_ok;

    // The reset vector is applied inside the datapath; only PC_VEC is chosen here.
    assign unused_ok = ^{Ir[7:1], RESET_VEC};
    assign op        = opcode_t'(Ir[15:12]);
    // A ready pulse only counts while the request is actually visible.
    assign mem_done  = MemReady && !Test && !Reset;

    cond_eval #(.COND_W(COND_W)) u_cond (
        .cond  (Ir[8 +: COND_W]),
        .flags (Flags),
        .taken (taken)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_RST;
        end else if (!Test) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        MemReq   = 1'b0;
        MemWrite = 1'b0;
        AluEn    = 1'b0;
        AluWe    = 1'b0;
        CFlag    = 1'b0;
        ImmSel   = 1'b0;
        IrWe     = 1'b0;
        LrEn     = 1'b0;
        LrSel    = 1'b0;
        LrWe     = 1'b0;
        MemEn    = 1'b0;
        Op1Sel   = 1'b0;
        PcEn     = 1'b0;
        PcWe     = 1'b0;
        RegWe    = 1'b0;
        WdSel    = 1'b0;
        Op2Sel   = OP2_RD2;
        PcSel    = PC_INC;
        Rs1Sel   = RSEL_NONE;
        RwSel    = RSEL_NONE;
        Halted   = 1'b0;

        if (state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
            if (is_alu(op) || op == OP_LDW || op == OP_STW) begin
                Rs1Sel = RSEL_A;
                RwSel  = RSEL_D;
            end
            if (op == OP_ADDI || op == OP_SUBI) begin
                Op2Sel = OP2_IMM;
                ImmSel = 1'b0;
            end
            if (op == OP_LDW || op == OP_STW) begin
                Op2Sel = OP2_IMM;
                ImmSel = 1'b1;
            end
        end

        case (state)
            ST_RST: begin
                PcSel      = PC_VEC;
                PcWe       = 1'b1;
                next_state = ST_FETCH;
            end
            ST_FETCH: begin
                PcEn   = 1'b1;
                MemReq = 1'b1;
                if (mem_done) begin
                    IrWe       = 1'b1;
                    PcWe       = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (op)
                    OP_NOP:  next_state = Ir[0] ? ST_HALT : ST_FETCH;
                    OP_BR:   next_state = taken ? ST_EXEC : ST_FETCH;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_SUBI,
                    OP_LDW, OP_STW, OP_BL, OP_RET: next_state = ST_EXEC;
                    default: next_state = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                next_state = ST_FETCH;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_SUBI: begin
                        AluEn      = 1'b1;
                        AluWe      = 1'b1;
                        next_state = ST_WB;
                    end
                    OP_LDW, OP_STW: begin
                        AluWe      = 1'b1;
                        next_state = ST_MEM;
                    end
                    OP_BR: begin
                        PcSel = PC_REL;
                        PcWe  = 1'b1;
                    end
                    OP_BL: begin
                        LrSel = 1'b0;
                        LrWe  = 1'b1;
                        PcSel = PC_REL;
                        PcWe  = 1'b1;
                    end
                    OP_RET: begin
                        LrEn  = 1'b1;
                        PcSel = PC_LR;
                        PcWe  = 1'b1;
                    end
                    default: next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                MemEn    = 1'b1;
                MemReq   = 1'b1;
                MemWrite = (op == OP_STW);
                if (mem_done) begin
                    if (op == OP_LDW) begin
                        RegWe = 1'b1;
                        WdSel = 1'b1;
                    end
                    next_state = ST_FETCH;
                end
            end
            ST_WB: begin
                RegWe      = 1'b1;
                WdSel      = 1'b0;
                CFlag      = (op == OP_SUB) || (op == OP_SUBI);
                next_state = ST_FETCH;
            end
            ST_HALT: begin
                Halted     = 1'b1;
                next_state = ST_HALT;
            end
            default: next_state = ST_RST;
        endcase

        // Scan freezes writes and withdraws the request; selects stay put.
        if (Test) begin
            RegWe    = 1'b0;
            PcWe     = 1'b0;
            IrWe     = 1'b0;
            AluWe    = 1'b0;
            LrWe     = 1'b0;
            MemReq   = 1'b0;
            MemWrite = 1'b0;
        end
        if (Reset) begin
            MemReq   = 1'b0;
            MemWrite = 1'b0;
            AluEn    = 1'b0;
            AluWe    = 1'b0;
            IrWe     = 1'b0;
            LrEn     = 1'b0;
            LrWe     = 1'b0;
            MemEn    = 1'b0;
            PcEn     = 1'b0;
            PcWe     = 1'b0;
            RegWe    = 1'b0;
        end
    end

endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Multi-cycle control FSM that sequences the 16-bit `datapath`.
- Consumes `Ir` and `Flags` from the datapath. Drives every datapath control input.
- Runs the external-memory handshake for instruction fetch and load/store.
- Sits beside `datapath` in the processor top. All datapath write enables come from this block only.

Parameters:
- RESET_VEC, 16'h0000, PC value loaded via PcSel=PC_VEC in the reset state (passed to datapath top; the controller only selects it).
- COND_W, 4, width of the branch condition field Ir[11:8].

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Ir  in  16  instruction register from datapath.
- Flags  in  4  {N,Z,C,V} = Flags[3:0], registered ALU flags.
- Test  in  1  scan mode: FSM frozen, all write enables forced 0.
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access request, held until MemReady.
- MemWrite  out  1  qualifies MemReq as a store.
- AluEn, AluWe, CFlag, ImmSel, IrWe, LrEn, LrSel, LrWe, MemEn, Op1Sel, PcEn, PcWe, RegWe, WdSel  out  1 each  datapath controls.
- Op2Sel, PcSel, Rs1Sel, RwSel  out  2 each  datapath mux selects.
- Halted  out  1  core stopped on HALT.

Behaviour:
- Opcode = Ir[15:12]:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR: reg-reg.
  - 0100 ADDI, 0101 SUBI: Op2Sel=OP2_IMM, ImmSel=0.
  - 1000 LDW, 1001 STW: addr = Rs1 + Imm.
  - 1100 BR: cond Ir[11:8].
  - 1101 BL.
  - 1110 RET.
  - 1111 NOP; HALT if Ir[0]=1.
  - Undefined opcodes execute as NOP.
- Conditions: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 V. Codes 8-15 are never-taken.
- States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are Moore functions of state and Ir, except the ready-qualified enables listed below, which are combinational on MemReady.
- RST:
  - PcSel=PC_VEC, PcWe=1.
  - Next state FETCH.
- FETCH:
  - PcEn=1, MemEn=0, MemReq=1.
  - When MemReady=1: IrWe=1 and PcWe=1 with PcSel=PC_INC; next state DECODE.
  - Otherwise stay in FETCH with all enables 0.
- DECODE:
  - Drive Rs1Sel/RwSel; no enables.
  - Next: HALT if HALT; FETCH if NOP, undefined, or untaken BR; otherwise EXEC.
- EXEC:
  - ALU ops: AluEn=1, AluWe=1; next WB.
  - LDW/STW: AluWe=1 (address); next MEM.
  - BR taken: PcSel=PC_REL, PcWe=1; next FETCH.
  - BL: LrSel=0, LrWe=1, PcSel=PC_REL, PcWe=1; next FETCH.
  - RET: LrEn=1, PcSel=PC_LR, PcWe=1; next FETCH.
- MEM:
  - MemEn=1, MemReq=1, MemWrite=STW.
  - On MemReady: LDW asserts RegWe=1 and WdSel=1; next FETCH.
  - Stays in MEM while MemReady=0.
- WB:
  - RegWe=1, WdSel=0, CFlag=carry-in for SUB/SUBI (1), else 0.
  - Next FETCH.
- HALT: Halted=1, all enables 0, stays until Reset.
- Latency with zero wait states:
  - ALU op: 4 cycles FETCH→WB.
  - LDW/STW: 4 cycles.
  - Taken BR/BL/RET: 3 cycles.
  - Untaken BR/NOP: 2 cycles.
- Enable pulses: every write enable is asserted for exactly one cycle per instruction. MemReq never drops before MemReady.
- Reset:
  - Reset=1 sampled on any edge → state RST, MemReq=0, all enables 0, Halted=0.
  - Reset dominates Test and MemReady, including mid-access.
- Test=1:
  - State register holds.
  - RegWe, PcWe, IrWe, AluWe, LrWe, MemReq forced 0; selects keep their values.
  - On Test falling, the FSM resumes in the held state. An in-flight access is re-requested.
- MemReady while MemReq=0 is ignored.

Decomposition:
- Package `ctrl_pkg` holds:
  - `state_t` enum.
  - `opcode_t` enum.
  - Condition-code constants.
  - Mux-select constants: PC_INC=2'b00, PC_REL=2'b01, PC_LR=2'b10, PC_VEC=2'b11; OP2_RD2=2'b00, OP2_IMM=2'b01, OP2_ONE=2'b10.
- Sub-module `cond_eval`: combinational Ir[11:8] × Flags → Taken.
- FSM and output decode stay in `datapath_ctrl`.

Test Plan:
- Reset 2 cycles then release → cycle after: PcWe=1, PcSel=2'b11. Next cycle MemReq=1, all other enables 0.
- ADD (Ir=16'h0xxx), MemReady tied 1 → IrWe at cycle 1, AluEn/AluWe at cycle 3, RegWe=1/WdSel=0 at cycle 4, back in FETCH at cycle 5.
- LDW with MemReady low for 3 MEM cycles → MemReq/MemEn held 4 cycles. RegWe=1 and WdSel=1 asserted only in the MemReady cycle, exactly once.
- BR cond=1 (Z): Flags=4'b0100 → PcWe=1, PcSel=2'b01 in EXEC. Flags=4'b0000 → no PcWe; FETCH directly after DECODE.
- Reset asserted during MEM of STW with MemReady=0 → next cycle MemReq=0, state RST. Then PcWe with PC_VEC, then a normal fetch.
- Test=1 for 5 cycles mid-EXEC → no write enables, state unchanged. After Test=0, AluWe pulses once. HALT opcode → Halted=1 held 10 cycles until Reset.
